// File: rtl/serial_subtractor_8bit_if.sv
// Start/operand request and result bus of the bit-serial subtractor.
// The master drives the request; the slave returns busy/done and the results.
interface serial_subtractor_8bit_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, ovf, zero);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, ovf, zero);
endinterface

// File: rtl/serial_subtractor_8bit.sv
// 8-bit bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// The work is done by a single full-subtractor cell and a borrow flop; results are held until the next completion.
module serial_subtractor_8bit (
  input  logic                          clk,
  input  logic                          rst,
  serial_subtractor_8bit_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  logic [7:0] a_sh, b_sh, d_sh;
  logic       br;
  logic [2:0] cnt;
  logic       a7_q, b7_q;

  logic       x, y, d, br_nxt;
  logic [7:0] d_nxt;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    x      = a_sh[0];
    y      = b_sh[0];
    d      = x ^ y ^ br;
    br_nxt = (~x & y) | (~(x ^ y) & br);
    d_nxt  = {d, d_sh[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      a7_q     <= 1'b0;
      b7_q     <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            br       <= bus.bin;
            a7_q     <= bus.a[7];
            b7_q     <= bus.b[7];
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        SHIFT: begin
          a_sh <= {1'b0, a_sh[7:1]};
          b_sh <= {1'b0, b_sh[7:1]};
          d_sh <= d_nxt;
          br   <= br_nxt;
          cnt  <= cnt + 3'd1;
          // Last bit: publish results in the same edge that enters DONE
          if (cnt == 3'd7) begin
            bus.diff <= d_nxt;
            bus.bout <= br_nxt;
            bus.zero <= (d_nxt == 8'h00);
            bus.ovf  <= (a7_q != b7_q) && (d != a7_q);
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
